// File: rtl/multiply_divide_unit_pkg.sv
// multiply_divide_unit_pkg
//   Shared types and constants for the multiply/divide unit.
//   - mdu_op_t    : MDU opcode encoding driven by the execute stage
//   - mdu_state_t : sequencer states (idle, multiply in flight, divide in flight)
//   - DIV_STEPS   : quotient bits produced by the restoring divider
//   - abs32 / negate_if : sign helpers for signed division

package multiply_divide_unit_pkg;

    typedef enum logic [3:0] {
        MDU_DISABLED = 4'd0,
        MDU_MULT     = 4'd1,
        MDU_MULTU    = 4'd2,
        MDU_DIV      = 4'd3,
        MDU_DIVU     = 4'd4,
        MDU_MTHI     = 4'd5,
        MDU_MTLO     = 4'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } mdu_state_t;

    localparam int          DIV_STEPS         = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    // Two's-complement magnitude; 32'h80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multiply_divide_unit_if.sv
// multiply_divide_unit_if
//   Request/result bundle between the execute stage and the MDU.
//   - start : request valid this cycle (only honoured while busy=0)
//   - op    : MDU opcode (mdu_op_t encoding)
//   - A, B  : rs / rt operands
//   - busy  : operation in flight, HI/LO not yet committed
//   - hi,lo : architectural HI/LO registers
//   Modports: master = execute stage, slave = MDU.

interface multiply_divide_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, A, B, input  busy, hi, lo);
    modport slave  (input  start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/multiply_divide_unit_iterative_divider.sv
// iterative_divider
//   Unsigned 32-bit restoring divider, one quotient bit per clock.
//   - clk, reset : clock, synchronous active-high reset
//   - load       : capture dividend/divisor and begin 32 iterations
//   - dividend, divisor : unsigned operands
//   - quotient, remainder : valid once done=1 after a load
//   - done       : no iterations outstanding
//   A divisor of zero runs the same 32 steps; the result is meaningless and
//   is replaced by the caller.

module iterative_divider
    import multiply_divide_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [5:0]  steps_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] divisor_q;

    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor. When the trial fits, the true difference is below
    // the divisor, so the low 32 bits of the subtraction are exact.
    always_comb begin
        shifted = {rem_q, quot_q[31]};
        fits    = (shifted >= {1'b0, divisor_q});
        diff    = shifted[31:0] - divisor_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            steps_q <= '0;
        end else if (load) begin
            steps_q <= 6'(DIV_STEPS);
        end else if (steps_q != '0) begin
            steps_q <= steps_q - 6'd1;
        end
    end

    // NOTE: the datapath registers carry no reset; their contents are only
    // looked at after a load has initialised them, so reset would add fanout
    // on the reset net for nothing.
    always_ff @(posedge clk) begin
        if (load) begin
            quot_q    <= dividend;
            rem_q     <= '0;
            divisor_q <= divisor;
        end else if (steps_q != '0) begin
            quot_q <= {quot_q[30:0], fits};
            rem_q  <= fits ? diff : shifted[31:0];
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign done      = (steps_q == '0);

endmodule

// File: rtl/multiply_divide_unit.sv
// multiply_divide_unit
//   Multi-cycle integer multiply/divide unit owning the HI/LO registers.
//   - MULT_CYCLES : busy duration of MULT/MULTU (must be >= 1)
//   - clk, reset  : clock, synchronous active-high reset
//   - bus         : slave side of multiply_divide_unit_if
//                   (start/op/A/B in, busy/hi/lo out)
//   MULT/MULTU hold busy for MULT_CYCLES cycles, DIV/DIVU for 33 (32 divider
//   steps plus a commit/sign-fix cycle). HI/LO change only at the commit edge,
//   which is the same edge busy falls. MTHI/MTLO write in the accepting edge.

module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    multiply_divide_unit_if.slave   bus
);

    localparam int CNT_MAX = (MULT_CYCLES - 1 > DIV_STEPS) ? (MULT_CYCLES - 1) : DIV_STEPS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_t  state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    mdu_op_t     op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        latch_operands;

    logic        div_load;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;

    logic [63:0] product;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    // Signed DIV feeds magnitudes to the unsigned core; the signs are
    // restored from the latched operands at commit.
    always_comb begin
        div_dividend = (mdu_op_t'(bus.op) == MDU_DIV) ? abs32(bus.A) : bus.A;
        div_divisor  = (mdu_op_t'(bus.op) == MDU_DIV) ? abs32(bus.B) : bus.B;
    end

    iterative_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .done      (div_done)
    );

    // Sign-extending to 64 bits makes the low 64 bits of the product equal
    // to the signed product, so one multiplier form covers both opcodes.
    always_comb begin
        if (op_q == MDU_MULT) begin
            product = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end else begin
            product = {32'd0, a_q} * {32'd0, b_q};
        end
    end

    // Divide-by-zero is overridden here. The 32'h80000000 / -1 case needs no
    // special handling: magnitudes 2^31 / 1 give quotient 32'h80000000 with
    // equal signs, so no negation is applied and the remainder is zero.
    always_comb begin
        if (b_q == '0) begin
            div_lo = DIV_ZERO_QUOTIENT;
            div_hi = a_q;
        end else if (op_q == MDU_DIV) begin
            div_lo = negate_if(a_q[31] ^ b_q[31], div_quotient);
            div_hi = negate_if(a_q[31], div_remainder);
        end else begin
            div_lo = div_quotient;
            div_hi = div_remainder;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        latch_operands = 1'b0;
        div_load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (mdu_op_t'(bus.op))
                        MDU_MULT, MDU_MULTU: begin
                            latch_operands = 1'b1;
                            state_d        = ST_MUL;
                            count_d        = CNT_W'(MULT_CYCLES - 1);
                        end
                        MDU_DIV, MDU_DIVU: begin
                            latch_operands = 1'b1;
                            div_load       = 1'b1;
                            state_d        = ST_DIV;
                            count_d        = CNT_W'(DIV_STEPS);
                        end
                        MDU_MTHI: hi_d = bus.A;
                        MDU_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end

            ST_MUL: begin
                if (count_q == '0) begin
                    {hi_d, lo_d} = product;
                    state_d      = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            ST_DIV: begin
                // count 0 is the commit/sign-fix cycle; the divider has
                // finished its 32 steps exactly at that point.
                if (count_q == '0 && div_done) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_operands) begin
            op_q <= mdu_op_t'(bus.op);
            a_q  <= bus.A;
            b_q  <= bus.B;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// tb_multiply_divide_unit
//   Self-checking bench for multiply_divide_unit. A behavioural model
//   (plain 64-bit arithmetic, SV / and %) predicts HI/LO and busy length.

module tb_multiply_divide_unit;
    import multiply_divide_unit_pkg::*;

    localparam int MC      = 5;
    localparam int DIV_LAT = 33;
    localparam int BOUND   = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiply_divide_unit_if bus ();

    multiply_divide_unit #(.MULT_CYCLES(MC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    bit          allow_overlap = 1'b0;

    // A start while busy is a pipeline bug unless a test provokes it on purpose.
    always @(negedge clk) begin
        #1;
        if (reset === 1'b0 && bus.start === 1'b1 && bus.busy === 1'b1 && !allow_overlap) begin
            n_mismatched++;
            $display("FAIL start_while_busy: start=1 busy=1 at %0t, required no overlap", $time);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_latency(input logic [3:0] o);
        case (o)
            MDU_MULT, MDU_MULTU: return MC;
            MDU_DIV, MDU_DIVU:   return DIV_LAT;
            default:             return 0;
        endcase
    endfunction

    task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MDU_MULT: begin
                p = sa * sb;
                {m_hi, m_lo} = p;
            end
            MDU_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge where busy=0; returns at the first negedge with
    // busy=0 after the operation, so consecutive calls are back-to-back.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        int          cyc;
        int          expc;
        bit          hold_bad;
        logic [31:0] hold_hi, hold_lo;
        expc     = exp_latency(o);
        hold_hi  = m_hi;
        hold_lo  = m_lo;
        hold_bad = 1'b0;
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = MDU_DISABLED;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < BOUND) begin
            if (bus.hi !== hold_hi || bus.lo !== hold_lo) hold_bad = 1'b1;
            cyc++;
            @(negedge clk);
        end
        model_apply(o, a, b);
        if (expc > 0) begin
            n_compared++;
            if (hold_bad) begin
                n_mismatched++;
                $display("FAIL %s hold: hi/lo changed during busy, required %h/%h", name, hold_hi, hold_lo);
            end
        end
        n_compared++;
        if (cyc !== expc) begin
            n_mismatched++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, cyc, expc);
        end
        n_compared++;
        if (bus.hi !== m_hi) begin
            n_mismatched++;
            $display("FAIL %s hi: got %h required %h (op=%0d A=%h B=%h)", name, bus.hi, m_hi, o, a, b);
        end
        n_compared++;
        if (bus.lo !== m_lo) begin
            n_mismatched++;
            $display("FAIL %s lo: got %h required %h (op=%0d A=%h B=%h)", name, bus.lo, m_lo, o, a, b);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op    = MDU_DISABLED;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        n_compared++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_mismatched++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
        n_compared++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
            n_mismatched++;
            $display("FAIL mult_const: got %h_%h required ffffffff_ffffffeb", bus.hi, bus.lo);
        end
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        n_compared++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            n_mismatched++;
            $display("FAIL multu_const: got %h_%h required fffffffe_00000001", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        run_op(MDU_DIV,  32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        n_compared++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            n_mismatched++;
            $display("FAIL div_const: got hi=%h lo=%h required ffffffff/fffffffd", bus.hi, bus.lo);
        end
        run_op(MDU_DIVU, 32'd100, 32'd7, "divu_100by7");
        n_compared++;
        if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            n_mismatched++;
            $display("FAIL divu_const: got hi=%h lo=%h required 2/14", bus.hi, bus.lo);
        end
        run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, "div_7byneg2");
    endtask

    task automatic test_boundaries();
        run_op(MDU_DIVU, 32'h1234_5678, 32'd0, "divu_by_zero");
        n_compared++;
        if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'hFFFF_FFFF) begin
            n_mismatched++;
            $display("FAIL divu_zero_const: got hi=%h lo=%h required 12345678/ffffffff", bus.hi, bus.lo);
        end
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        n_compared++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
            n_mismatched++;
            $display("FAIL div_overflow_const: got hi=%h lo=%h required 0/80000000", bus.hi, bus.lo);
        end
        run_op(MDU_DIV, 32'hFFFF_FFF0, 32'd0, "div_by_zero");
    endtask

    task automatic test_move();
        run_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi");
        run_op(MDU_MTLO, 32'd5,         32'd0, "mtlo");
        n_compared++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'd5) begin
            n_mismatched++;
            $display("FAIL move_const: got hi=%h lo=%h required deadbeef/00000005", bus.hi, bus.lo);
        end
        run_op(MDU_DISABLED, 32'h1111_1111, 32'h2222_2222, "disabled");
        run_op(4'hF,         32'h3333_3333, 32'h4444_4444, "undefined_op");
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [3:0] o;
        int         r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 8);
            o = (r <= 6) ? 4'(r) : ((r == 7) ? 4'h9 : 4'hF);
            run_op(o, rand_operand(), rand_operand(), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_busy_overlap();
        int cyc;
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.A     = 32'd1000;
        bus.B     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < BOUND) begin
            cyc++;
            if (cyc == 10) begin
                bus.start     = 1'b1;
                bus.op        = MDU_MTHI;
                bus.A         = 32'hDEAD_BEEF;
                allow_overlap = 1'b1;
            end else begin
                bus.start     = 1'b0;
                bus.op        = MDU_DISABLED;
                allow_overlap = 1'b0;
            end
            @(negedge clk);
        end
        bus.start     = 1'b0;
        allow_overlap = 1'b0;
        model_apply(MDU_DIVU, 32'd1000, 32'd7);
        n_compared++;
        if (cyc !== DIV_LAT) begin
            n_mismatched++;
            $display("FAIL overlap busy_cycles: got %0d required %0d", cyc, DIV_LAT);
        end
        n_compared++;
        if (bus.hi !== m_hi || bus.lo !== m_lo) begin
            n_mismatched++;
            $display("FAIL overlap result: got hi=%h lo=%h required %h/%h", bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        bit bad;
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.A     = $urandom;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 15) begin
            cyc++;
            if (cyc == 15) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        n_compared++;
        if (cyc !== 15 || bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_mismatched++;
            $display("FAIL reset_mid_op: cyc=%0d busy=%b hi=%h lo=%h required 15/0/0/0",
                     cyc, bus.busy, bus.hi, bus.lo);
        end
        bad = 1'b0;
        repeat (40) begin
            if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) bad = 1'b1;
            @(negedge clk);
        end
        n_compared++;
        if (bad) begin
            n_mismatched++;
            $display("FAIL reset_no_late_commit: state changed after reset, required busy=0 hi=lo=0");
        end
        run_op(MDU_MULT, 32'h0001_2345, 32'hFFFF_0003, "mult_after_reset");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_boundaries();
        test_move();
        test_back_to_back();
        test_busy_overlap();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
